// File: rtl/rv32_pkg.sv
// Shared defaults and types for the RV32I integer register file.
package rv32_pkg;

  localparam int unsigned XLEN_DEFAULT  = 32;
  localparam int unsigned NREGS_DEFAULT = 32;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic {S_INIT, S_READY} rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: flush beats issue, issue beats writeback; x0 is never busy.
module rf_scoreboard
  import rv32_pkg::*;
#(
  parameter  int unsigned NREGS  = NREGS_DEFAULT,
  parameter  int unsigned NRD    = 2,
  parameter  int unsigned NWR    = 1,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] rs_addr,
  output logic [NRD-1:0]    rs_busy
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < int'(NWR); j++) begin
      if (wr_en[j]) wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (active) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        for (int r = 1; r < int'(NREGS); r++) begin
          if (iss_valid && iss_rd == AW'(r)) busy_d[r] = 1'b1;
          else if (wr_hit[r])                busy_d[r] = 1'b0;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // With bypass, a register being written this cycle is forwarded and so is usable.
  always_comb begin
    rs_busy = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      rs_busy[i] = active && busy_q[rs_addr[i*AW +: AW]] &&
                   !((BYPASS != 0) && wr_hit[rs_addr[i*AW +: AW]]);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Pipelined RV32I register file: async reads, sync writes with optional bypass,
// post-reset zeroing sweep and a busy scoreboard for hazard detection.
module regfile_scoreboard
  import rv32_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEFAULT,
  parameter  int unsigned NREGS  = NREGS_DEFAULT,
  parameter  int unsigned NRD    = 2,
  parameter  int unsigned NWR    = 1,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                flush,
  output logic                init_done
);

  rf_state_e       state_q;
  logic [AW-1:0]   idx_q;
  logic            init_done_q;
  logic            active;
  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          idx_q <= idx_q + AW'(1);
          if (idx_q == AW'(NREGS - 1)) begin
            state_q     <= S_READY;
            init_done_q <= 1'b1;
          end
        end
        S_READY: ;
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign active    = (state_q == S_READY);
  assign init_done = init_done_q;
  assign iss_ready = init_done_q;

  // No reset on storage; the sweep zeroes it. Later ports override earlier ones.
  always_ff @(posedge clk) begin
    if (!active) begin
      mem_q[idx_q] <= '0;
    end else begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
          mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
    mem_q[0] <= '0;
  end

  always_comb begin
    rs_data = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      if (active && rs_addr[i*AW +: AW] != '0) begin
        rs_data[i*XLEN +: XLEN] = mem_q[rs_addr[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int j = 0; j < int'(NWR); j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == rs_addr[i*AW +: AW]) begin
              rs_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .BYPASS(BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (active),
    .flush    (flush),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rs_addr  (rs_addr),
    .rs_busy  (rs_busy)
  );

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised next-generation integer register file for the pipelined RV32I core. It provides NRD asynchronous read ports, NWR synchronous write ports with optional write-through bypass, and a hard-wired x0. It adds two things the single-cycle file lacks: a per-register busy scoreboard for hazard detection, and a post-reset initialisation sweep that zeroes every entry. It sits between decode/issue and writeback.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, at least 2)
NRD, 2, number of read ports
NWR, 1, number of write ports (1 or 2)
BYPASS, 1, 1 = same-cycle write-through to read ports; 0 = write visible next cycle only
AW, $clog2(NREGS), address width (derived localparam, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
rs_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rs_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rs_busy  out  NRD  read register has an outstanding producer
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
iss_valid  in  1  an instruction issues that will write iss_rd
iss_rd  in  AW  destination register of the issuing instruction
iss_ready  out  1  issue accepted (equals init_done)
flush  in  1  clear all busy bits (pipeline squash)
init_done  out  1  initialisation sweep complete

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- FSM states: S_INIT, S_READY. rst_n low forces S_INIT, sweep index = 0, all busy bits 0, init_done 0.
- S_INIT: write 0 to entry[idx] each cycle, idx increments. After the write of idx = NREGS-1, move to S_READY. init_done rises on the cycle after the final write, NREGS cycles after rst_n deasserts.
- During S_INIT: wr_en, iss_valid and flush are ignored; rs_data = 0; rs_busy = 0; iss_ready = 0.
- Reset asserted mid-sweep or mid-operation: immediately return to S_INIT, busy cleared, and the sweep restarts from 0.
- Storage array has no reset; only the FSM, the index and the busy bits are reset.
- Reads (S_READY): combinational. rs_addr = 0 returns 0 and rs_busy = 0.
  - BYPASS=1: if any enabled write targets rs_addr (≠0), rs_data = that wr_data.
  - BYPASS=0: rs_data = stored value.
- Writes: on posedge clk, entry[wr_addr[j]] <= wr_data[j] when wr_en[j] and wr_addr[j] ≠ 0. Writes to x0 are dropped, and x0 is re-forced to 0 every cycle.
- Two write ports to the same address: the higher port index wins for both storage and bypass.
- Scoreboard per register r ≠ 0, evaluated each S_READY cycle, in priority order:
  1. flush: all busy <= 0.
  2. iss_valid with iss_rd = r: busy[r] <= 1.
  3. Otherwise, an enabled write to r: busy[r] <= 0.
- Because issue beats writeback, a same-cycle issue and writeback to the same register leaves busy set. Because flush beats issue, a same-cycle flush and issue leaves busy clear.
- busy[0] is constant 0. iss_valid with iss_rd = 0 has no effect.
- rs_busy[i]:
  - BYPASS=1: busy[rs_addr[i]] AND NOT (an enabled write to rs_addr[i] this cycle), i.e. the forwarded value is usable.
  - BYPASS=0: busy[rs_addr[i]].
- Latency: write to read = 0 cycles with BYPASS=1, 1 cycle with BYPASS=0. Issue to busy visible = 1 cycle.
- Reset values: rs_data 0, rs_busy 0, iss_ready 0, init_done 0.

Decomposition:
- Package rv32_pkg: XLEN_DEFAULT, NREGS_DEFAULT, typedef reg_addr_t (logic [4:0]), typedef rf_state_e enum {S_INIT, S_READY}.
- One sub-module, rf_scoreboard: busy vector with set/clear/flush priority and the rs_busy lookup. Storage, bypass and the init FSM remain in the top module.

Test Plan:
- Reset release, NREGS=32 -> init_done is 0 for exactly 32 cycles, then 1. Reading x5 afterwards returns 0x00000000 and rs_busy = 0.
- Write x3 = 0xDEADBEEF while port 0 reads x3: BYPASS=1 -> rs_data0 = 0xDEADBEEF in the same cycle; BYPASS=0 -> old value, then 0xDEADBEEF on the next cycle.
- Write x0 = 0xFFFFFFFF -> x0 reads 0. Issue iss_rd = 0 -> rs_busy stays 0.
- Issue x7, then read x7 -> rs_busy = 1. Writeback x7 = 0x12 -> rs_busy = 0 in that cycle (BYPASS=1) and data is 0x12. Same-cycle issue and writeback on x7 -> busy remains 1.
- NWR=2, both ports write x9 (0x1 on port 0, 0x2 on port 1) -> x9 = 0x2. Issue x4 and x5, then flush -> both busy bits clear on the next cycle.
- Drop rst_n mid-sweep at index 10 -> FSM returns to S_INIT, the sweep restarts from 0, init_done follows 32 cycles after release, and earlier writes are lost.
